weight_update_controller: RTL and testbench

Sequencer that owns the write and update ports of the weight storage array (size x size x layer_size, Q8.8 words).
- LOAD pass: streams initial weights in from a load source.
- UPDATE pass: streams dc_dw gradient rows from backprop in reverse layer order.
- Each accepted beat becomes a one-cycle registered is_write or is_update strobe with matching layer/row indices.
The read port is not touched and stays with the forward datapath.

---
 rtl/weight_update_controller.sv | 230 +++++++++++++++++++++++
 tb/tb_weight_update_controller.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/weight_update_controller.sv
// weight_update_controller
// Owns the write and update ports of the weight storage array. A LOAD pass
// streams initial weight rows in layer order; an UPDATE pass streams dc_dw
// gradient rows in reverse layer order. Each accepted beat becomes a one-cycle
// registered is_write / is_update strobe carrying its layer/row indices.

module weight_update_controller #(
  parameter int unsigned data_size  = 16,
  parameter int unsigned size       = 3,
  parameter int unsigned layer_size = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_load,
  input  logic                      start_update,
  input  logic                      abort,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [data_size*size-1:0] load_data,
  input  logic                      grad_valid,
  output logic                      grad_ready,
  input  logic [data_size*size-1:0] grad_data,
  output logic [31:0]               write_layer_index,
  output logic [31:0]               write_row_index,
  output logic [data_size*size-1:0] write_data,
  output logic                      is_write,
  output logic [31:0]               layer_index,
  output logic [31:0]               row_index,
  output logic [data_size*size-1:0] dc_dw,
  output logic                      is_update,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               beats_done
);

  localparam int unsigned ROW_W      = data_size * size;
  localparam int unsigned IDX_W      = 32;
  localparam int unsigned LAST_ROW   = size - 1;
  localparam int unsigned LAST_LAYER = layer_size - 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_UPDATE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [IDX_W-1:0]   r_cur_layer;
  logic [IDX_W-1:0]   r_cur_row;
  logic [IDX_W-1:0]   r_beats_done;

  logic [IDX_W-1:0]   r_write_layer_index;
  logic [IDX_W-1:0]   r_write_row_index;
  logic [ROW_W-1:0]   r_write_data;
  logic               r_is_write;

  logic [IDX_W-1:0]   r_layer_index;
  logic [IDX_W-1:0]   r_row_index;
  logic [ROW_W-1:0]   r_dc_dw;
  logic               r_is_update;

  logic               w_load_beat;
  logic               w_grad_beat;
  logic               w_row_last;
  logic               w_load_last;
  logic               w_grad_last;
  logic               w_start_load;
  logic               w_start_update;

  // Position decode shared by next-state and counter logic
  assign w_row_last     = (r_cur_row == IDX_W'(LAST_ROW));
  assign w_load_last    = w_row_last && (r_cur_layer == IDX_W'(LAST_LAYER));
  assign w_grad_last    = w_row_last && (r_cur_layer == '0);
  assign w_start_load   = (r_state == S_IDLE) && start_load;
  assign w_start_update = (r_state == S_IDLE) && !start_load && start_update;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; LOAD wins a simultaneous start, abort returns to IDLE
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start_load) begin
          w_next_state = S_LOAD;
        end else if (start_update) begin
          w_next_state = S_UPDATE;
        end
      end
      S_LOAD: begin
        if (abort) begin
          w_next_state = S_IDLE;
        end else if (w_load_beat && w_load_last) begin
          w_next_state = S_DONE;
        end
      end
      S_UPDATE: begin
        if (abort) begin
          w_next_state = S_IDLE;
        end else if (w_grad_beat && w_grad_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Output decode from state: handshakes, busy and the done pulse
  always_comb begin
    load_ready  = 1'b0;
    grad_ready  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        load_ready = !abort;
        busy       = 1'b1;
      end
      S_UPDATE: begin
        grad_ready = !abort;
        busy       = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        done = 1'b0;
      end
    endcase
    w_load_beat = load_valid && load_ready;
    w_grad_beat = grad_valid && grad_ready;
  end

  // Row/layer cursor and beat counter; cursor holds after the final beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cur_layer  <= '0;
      r_cur_row    <= '0;
      r_beats_done <= '0;
    end else if (w_start_load) begin
      r_cur_layer  <= '0;
      r_cur_row    <= '0;
      r_beats_done <= '0;
    end else if (w_start_update) begin
      r_cur_layer  <= IDX_W'(LAST_LAYER);
      r_cur_row    <= '0;
      r_beats_done <= '0;
    end else if (w_load_beat) begin
      r_beats_done <= r_beats_done + IDX_W'(1);
      if (w_row_last) begin
        r_cur_row <= '0;
        if (!w_load_last) begin
          r_cur_layer <= r_cur_layer + IDX_W'(1);
        end
      end else begin
        r_cur_row <= r_cur_row + IDX_W'(1);
      end
    end else if (w_grad_beat) begin
      r_beats_done <= r_beats_done + IDX_W'(1);
      if (w_row_last) begin
        r_cur_row <= '0;
        if (!w_grad_last) begin
          r_cur_layer <= r_cur_layer - IDX_W'(1);
        end
      end else begin
        r_cur_row <= r_cur_row + IDX_W'(1);
      end
    end
  end

  // Storage write port: capture accepted load beat, strobe for one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write_layer_index <= '0;
      r_write_row_index   <= '0;
      r_write_data        <= '0;
      r_is_write          <= 1'b0;
    end else begin
      r_is_write <= w_load_beat;
      if (w_load_beat) begin
        r_write_layer_index <= r_cur_layer;
        r_write_row_index   <= r_cur_row;
        r_write_data        <= load_data;
      end
    end
  end

  // Storage update port: capture accepted gradient beat, strobe for one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_layer_index <= '0;
      r_row_index   <= '0;
      r_dc_dw       <= '0;
      r_is_update   <= 1'b0;
    end else begin
      r_is_update <= w_grad_beat;
      if (w_grad_beat) begin
        r_layer_index <= r_cur_layer;
        r_row_index   <= r_cur_row;
        r_dc_dw       <= grad_data;
      end
    end
  end

  assign write_layer_index = r_write_layer_index;
  assign write_row_index   = r_write_row_index;
  assign write_data        = r_write_data;
  assign is_write          = r_is_write;
  assign layer_index       = r_layer_index;
  assign row_index         = r_row_index;
  assign dc_dw             = r_dc_dw;
  assign is_update         = r_is_update;
  assign beats_done        = r_beats_done;

endmodule

// File: tb/tb_weight_update_controller.sv
// Directed bench for weight_update_controller: LOAD/UPDATE passes with
// continuous and gapped valid, simultaneous starts, abort and async reset.

module tb_weight_update_controller;

  localparam int unsigned DW   = 16;
  localparam int unsigned SZ   = 3;
  localparam int unsigned LS   = 5;
  localparam int unsigned RW   = DW * SZ;
  localparam int unsigned NBT  = SZ * LS;

  logic          clk;
  logic          reset;
  logic          start_load;
  logic          start_update;
  logic          abort;
  logic          load_valid;
  logic          load_ready;
  logic [RW-1:0] load_data;
  logic          grad_valid;
  logic          grad_ready;
  logic [RW-1:0] grad_data;
  logic [31:0]   write_layer_index;
  logic [31:0]   write_row_index;
  logic [RW-1:0] write_data;
  logic          is_write;
  logic [31:0]   layer_index;
  logic [31:0]   row_index;
  logic [RW-1:0] dc_dw;
  logic          is_update;
  logic          busy;
  logic          done;
  logic [31:0]   beats_done;

  int n_checks;
  int n_pass;

  weight_update_controller #(
    .data_size (DW),
    .size      (SZ),
    .layer_size(LS)
  ) u_dut (
    .clk              (clk),
    .reset            (reset),
    .start_load       (start_load),
    .start_update     (start_update),
    .abort            (abort),
    .load_valid       (load_valid),
    .load_ready       (load_ready),
    .load_data        (load_data),
    .grad_valid       (grad_valid),
    .grad_ready       (grad_ready),
    .grad_data        (grad_data),
    .write_layer_index(write_layer_index),
    .write_row_index  (write_row_index),
    .write_data       (write_data),
    .is_write         (is_write),
    .layer_index      (layer_index),
    .row_index        (row_index),
    .dc_dw            (dc_dw),
    .is_update        (is_update),
    .busy             (busy),
    .done             (done),
    .beats_done       (beats_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One pass: ld selects LOAD/UPDATE, valid asserted every 'period' cycles,
  // abort raised once abort_at beats are in (negative = never), both raises
  // start_update alongside start_load; a stray start_update is pulsed mid-pass.
  task automatic run_pass(input bit ld, input logic [RW-1:0] base, input logic [RW-1:0] inc,
                          input int period, input int abort_at, input bit both);
    int b;
    bit v;
    bit stop;
    logic [RW-1:0] d;
    logic [RW-1:0] dexp;
    int exp_layer;
    b = 0;
    stop = 1'b0;
    dexp = '0;
    @(posedge clk); #1;
    start_load   = ld | both;
    start_update = ~ld | both;
    @(posedge clk); #1;
    start_load   = 1'b0;
    start_update = 1'b0;
    check("busy_on", 64'(busy), 64'(1));
    check("beats_clr", 64'(beats_done), 64'(0));
    for (int c = 0; c < 200 && b < int'(NBT) && !stop; c++) begin
      v = ((c % period) == 0);
      d = base + inc * RW'(b);
      if (ld) begin
        load_valid = v;
        load_data  = d;
      end else begin
        grad_valid = v;
        grad_data  = d;
      end
      if (ld && c == 5) start_update = 1'b1;
      if (abort_at >= 0 && b == abort_at) begin
        abort = 1'b1;
        #1;
        check("abort_rdy", 64'(ld ? load_ready : grad_ready), 64'(0));
        @(posedge clk); #1;
        abort      = 1'b0;
        load_valid = 1'b0;
        grad_valid = 1'b0;
        @(negedge clk);
        check("abort_strobe", 64'(ld ? is_write : is_update), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_cnt", 64'(beats_done), 64'(abort_at));
        stop = 1'b1;
      end else begin
        #1;
        check("rdy", 64'(ld ? load_ready : grad_ready), 64'(1));
        check("other_rdy", 64'(ld ? grad_ready : load_ready), 64'(0));
        dexp = d;
        @(posedge clk); #1;
        start_update = 1'b0;
        @(negedge clk);
        check("strobe", 64'(ld ? is_write : is_update), 64'(v));
        check("other_strobe", 64'(ld ? is_update : is_write), 64'(0));
        if (v) begin
          exp_layer = ld ? (b / int'(SZ)) : (int'(LS) - 1 - b / int'(SZ));
          check("layer", 64'(ld ? write_layer_index : layer_index), 64'(exp_layer));
          check("row", 64'(ld ? write_row_index : row_index), 64'(b % int'(SZ)));
          check("data", 64'(ld ? write_data : dc_dw), 64'(dexp));
          b++;
        end
        check("done", 64'(done), 64'(b == int'(NBT)));
        check("beats", 64'(beats_done), 64'(b));
      end
    end
    if (!stop) begin
      check("pass_len", 64'(b), 64'(NBT));
      load_valid = 1'b0;
      grad_valid = 1'b0;
      check("done_busy", 64'(busy), 64'(0));
      check("done_rdy", 64'(load_ready | grad_ready), 64'(0));
      @(negedge clk);
      check("post_strobe", 64'(is_write | is_update), 64'(0));
      check("post_done", 64'(done), 64'(0));
      check("post_busy", 64'(busy), 64'(0));
      check("post_beats", 64'(beats_done), 64'(NBT));
    end
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    reset        = 1'b1;
    start_load   = 1'b0;
    start_update = 1'b0;
    abort        = 1'b0;
    load_valid   = 1'b0;
    load_data    = '0;
    grad_valid   = 1'b0;
    grad_data    = '0;
    #11;
    check("rst_write", 64'(is_write), 64'(0));
    check("rst_update", 64'(is_update), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_beats", 64'(beats_done), 64'(0));
    check("rst_wdata", 64'(write_data), 64'(0));
    check("rst_rdy", 64'(load_ready | grad_ready), 64'(0));
    #1 reset = 1'b0;

    // LOAD, continuous valid, rows advance in the low word per beat
    run_pass(1'b1, RW'(48'h0100_0100_0100), RW'(48'h1), 1, -1, 1'b0);
    // UPDATE, continuous valid, constant 0x0040 words
    run_pass(1'b0, RW'(48'h0040_0040_0040), RW'(0), 1, -1, 1'b0);
    // UPDATE, valid 1,0,0,1,0,0...
    run_pass(1'b0, RW'(48'h1111_2222_3333), RW'(48'h0001_0001_0001), 3, -1, 1'b0);
    // both starts together: LOAD wins, grad_ready never rises
    run_pass(1'b1, RW'(48'h7fff_8000_0001), RW'(48'h10), 1, -1, 1'b1);
    // abort after 7 UPDATE beats, then a clean restart from (4,0)
    run_pass(1'b0, RW'(48'h0abc_0def_0123), RW'(48'h1), 1, 7, 1'b0);
    run_pass(1'b0, RW'(48'h0040_0040_0040), RW'(0), 1, -1, 1'b0);

    // async reset while is_update is high
    @(posedge clk); #1;
    start_update = 1'b1;
    @(posedge clk); #1;
    start_update = 1'b0;
    grad_valid   = 1'b1;
    grad_data    = RW'(48'h5555_aaaa_5555);
    @(posedge clk); #1;
    check("pre_rst_upd", 64'(is_update), 64'(1));
    #2 reset = 1'b1;
    #1;
    check("arst_upd", 64'(is_update), 64'(0));
    check("arst_dcdw", 64'(dc_dw), 64'(0));
    check("arst_layer", 64'(layer_index), 64'(0));
    check("arst_beats", 64'(beats_done), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_rdy", 64'(grad_ready), 64'(0));
    @(negedge clk);
    check("arst_negedge", 64'(is_update), 64'(0));
    #1;
    reset      = 1'b0;
    grad_valid = 1'b0;
    @(negedge clk);
    check("arst_idle", 64'(busy), 64'(0));
    check("arst_noupd", 64'(is_update), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
